pipe_stage_reg: RTL and testbench
=================================

# pipe_stage_reg

Parametrised pipeline stage register with a valid/ready handshake, a two-entry skid buffer and a synchronous flush. It sits between stages of the processor pipeline, such as IF/ID or ID/EX. It sustains one transfer per cycle with one cycle of latency, and it breaks the combinational ready path between stages. It replaces plain load-enable registers wherever a stage must stall or be squashed.

## Interface
Parameters:
- `WIDTH`, default 32: payload width in bits.
- `RESET_VAL`, default 0: value of `out_data` and of both entries after reset or flush.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, synchronous and active-low. Sampled on the rising edge of `clk`.
- `flush` in 1: synchronous squash of all held entries.
- `in_valid` in 1: upstream has data.
- `in_ready` out 1: stage can accept. Driven from registered state only.
- `in_data` in WIDTH: upstream payload.
- `out_valid` out 1: `out_data` is valid.
- `out_ready` in 1: downstream accepts.
- `out_data` out WIDTH: registered payload.
- `stall_cnt` out 32: present only with `PIPE_REG_PERF_EN`.

## Operation
- There are two entries, MAIN and SKID, and a three-state FSM: EMPTY, BUSY and FULL.
- `out_data` is MAIN. `out_valid` is 1 in BUSY and FULL. `in_ready` is 1 in EMPTY and BUSY.
- An upstream transfer occurs when `in_valid && in_ready`. A downstream transfer occurs when `out_valid && out_ready`.
- EMPTY:
  - On `in_valid`: MAIN <= `in_data`, go to BUSY.
- BUSY:
  - On in and out transfer together: MAIN <= `in_data`, stay in BUSY.
  - On in transfer only: SKID <= `in_data`, go to FULL.
  - On out transfer only: go to EMPTY.
  - With no transfer: hold.
- FULL:
  - `in_data` and `in_valid` are ignored.
  - On `out_ready`: MAIN <= SKID, go to BUSY.
  - Otherwise: hold.
- Priority is `rst` low, then `flush`, then the handshake.
- Flush:
  - Next state is EMPTY and both entries return to `RESET_VAL`.
  - Any transfer in the flush cycle is discarded: upstream data is dropped, and the downstream consumer must disregard it.
- Reset:
  - Next state is EMPTY. `out_valid`=0, `out_data`=`RESET_VAL`, `in_ready`=1 from the first cycle after reset.
  - Handshakes during reset cycles are discarded.
  - Reset mid-operation drops both entries without draining them.
- Stability: while `out_valid && !out_ready`, `out_data` must not change.
- Ordering is strictly FIFO: SKID data never overtakes MAIN.

## Timing
- Latency is one cycle. Data accepted at edge N appears on `out_data` after edge N, when BUSY or FULL is entered from empty.
- Throughput is one transfer per cycle while `out_ready` stays high.
- `in_ready` deasserts in the cycle after the first downstream stall (BUSY -> FULL). SKID absorbs the one word that was in flight.
- `in_ready` reasserts in the cycle after `out_ready` drains FULL.
- No combinational path exists from `out_ready` or `in_valid` to any output.
- `flush` or `rst` is visible on the outputs after exactly one edge.

## Configuration
- `PIPE_REG_PERF_EN` defined:
  - Adds the `stall_cnt` output.
  - The counter increments every cycle with `out_valid && !out_ready`.
  - It saturates at 0xFFFF_FFFF.
  - It is cleared only by `rst`, not by `flush`.
- `PIPE_REG_PERF_EN` undefined:
  - No `stall_cnt` port and no counter logic.
  - Handshake behaviour is identical.

## Structure
- Shared package `pipe_pkg`:
  - State typedef `pipe_state_t` with EMPTY=2'b00, BUSY=2'b01, FULL=2'b10.
  - Constant `STALL_CNT_W`=32.
- One sub-module, `pipe_reg_slot`:
  - A WIDTH-bit register with load enable and synchronous active-low reset to `RESET_VAL`.
  - Instantiated twice, for MAIN and SKID.
- The FSM and counter live in the top module.

## Test plan
- Streaming: `out_ready`=1, `in_valid`=1 with data 1,2,3,4 on consecutive cycles -> `out_data` 1,2,3,4 one cycle later, `in_ready` constantly 1.
- Backpressure:
  - Stimulus: stream 0xA,0xB,0xC, drop `out_ready` when 0xA is presented, hold it low for 3 cycles.
  - Required: `out_data` stays 0xA and SKID holds 0xB; `in_ready` goes to 0 the following cycle; 0xC is not accepted until ready returns.
  - On release: output 0xA,0xB,0xC in order with no loss or duplication.
- Flush in FULL: enter FULL, assert `flush` together with `out_ready`=1 and `in_valid`=1 -> next cycle `out_valid`=0, `out_data`=`RESET_VAL`, `in_ready`=1, and neither held word ever appears.
- Reset mid-stream: drive `rst`=0 for one edge while BUSY -> EMPTY, `out_valid`=0 and `in_ready`=1 next cycle; data offered during reset is not emitted.
- Idle hold: BUSY with `in_valid`=0 and `out_ready`=0 for 10 cycles -> `out_data` unchanged and `out_valid`=1 throughout.
- With `PIPE_REG_PERF_EN`:
  - Stall the output for 5 cycles -> `stall_cnt`=5.
  - Apply `flush` -> `stall_cnt` stays 5.
  - Apply `rst` -> `stall_cnt`=0.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared types for the pipeline stage register: handshake FSM state encoding and counter width.
package pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    BUSY  = 2'b01,
    FULL  = 2'b10
  } pipe_state_t;

  localparam int STALL_CNT_W = 32;

endpackage

// File: rtl/pipe_reg_slot.sv
// One payload entry: load-enabled register with synchronous active-low reset and clear to RESET_VAL.
// Single-cycle write, no handshake of its own; the owner decides when to load or clear.
module pipe_reg_slot #(
  parameter int              WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk) begin
    if (!rst) begin
      q <= RESET_VAL;
    end else if (clr) begin
      q <= RESET_VAL;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Valid/ready pipeline register with 2-entry skid buffer and flush; 1-cycle latency, full throughput,
// in_ready depends only on registered state. PIPE_REG_PERF_EN adds a saturating stall_cnt output.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int              WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WIDTH-1:0]       in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH-1:0]       out_data
`ifdef PIPE_REG_PERF_EN
  ,
  output logic [STALL_CNT_W-1:0] stall_cnt
`endif
);

  pipe_state_t      state_q;
  pipe_state_t      state_d;
  logic             main_load;
  logic             main_from_skid;
  logic             skid_load;
  logic [WIDTH-1:0] main_d;
  logic [WIDTH-1:0] main_q;
  logic [WIDTH-1:0] skid_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // FULL ignores in_valid entirely; in_ready is already low there.
  always_comb begin
    state_d        = state_q;
    main_load      = 1'b0;
    main_from_skid = 1'b0;
    skid_load      = 1'b0;
    case (state_q)
      EMPTY: begin
        if (in_valid) begin
          main_load = 1'b1;
          state_d   = BUSY;
        end
      end
      BUSY: begin
        if (in_valid && out_ready) begin
          main_load = 1'b1;
        end else if (in_valid) begin
          skid_load = 1'b1;
          state_d   = FULL;
        end else if (out_ready) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (out_ready) begin
          main_load      = 1'b1;
          main_from_skid = 1'b1;
          state_d        = BUSY;
        end
      end
      default: begin
        state_d = EMPTY;
      end
    endcase
    if (flush) begin
      state_d   = EMPTY;
      main_load = 1'b0;
      skid_load = 1'b0;
    end
  end

  assign main_d = main_from_skid ? skid_q : in_data;

  pipe_reg_slot #(
    .WIDTH     (WIDTH),
    .RESET_VAL (RESET_VAL)
  ) u_main (
    .clk  (clk),
    .rst  (rst),
    .clr  (flush),
    .load (main_load),
    .d    (main_d),
    .q    (main_q)
  );

  pipe_reg_slot #(
    .WIDTH     (WIDTH),
    .RESET_VAL (RESET_VAL)
  ) u_skid (
    .clk  (clk),
    .rst  (rst),
    .clr  (flush),
    .load (skid_load),
    .d    (in_data),
    .q    (skid_q)
  );

  assign out_data  = main_q;
  assign out_valid = (state_q == BUSY) || (state_q == FULL);
  assign in_ready  = (state_q == EMPTY) || (state_q == BUSY);

`ifdef PIPE_REG_PERF_EN
  // Survives flush on purpose so stall history spans squashes; only reset clears it.
  always_ff @(posedge clk) begin
    if (!rst) begin
      stall_cnt <= '0;
    end else if (out_valid && !out_ready && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg with a data scoreboard checked on every downstream transfer.
module tb_pipe_stage_reg;
  localparam int          W  = 32;
  localparam logic [31:0] RV = 32'h5A5A_0000;

  logic          clk = 1'b0;
  logic          rst;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_data;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_data;
`ifdef PIPE_REG_PERF_EN
  logic [31:0]   stall_cnt;
`endif

  int            n_assert = 0;
  int            n_fail   = 0;
  logic [W-1:0]  sb_q[$];

  always #5 clk = ~clk;

  pipe_stage_reg #(
    .WIDTH     (W),
    .RESET_VAL (RV)
  ) u_dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
`ifdef PIPE_REG_PERF_EN
    ,
    .stall_cnt (stall_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Record handshakes from the stable mid-cycle values, then advance one edge.
  task automatic tick();
    logic [W-1:0] exp;
    if (!rst || flush) begin
      sb_q.delete();
    end else begin
      if (out_valid && out_ready) begin
        exp = (sb_q.size() > 0) ? sb_q.pop_front() : 'x;
        chk("sb_data", out_data, exp);
      end
      if (in_valid && in_ready) sb_q.push_back(in_data);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    @(posedge clk); #1;
    tick();
    rst = 1'b1;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_in_ready",  {31'd0, in_ready},  32'd1);
    chk("rst_out_data",  out_data, RV);

    // Streaming at full rate
    out_ready = 1'b1; in_valid = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      in_data = i;
      tick();
      chk("stream_in_ready",  {31'd0, in_ready},  32'd1);
      chk("stream_out_valid", {31'd0, out_valid}, 32'd1);
      chk("stream_out_data",  out_data, i);
    end
    in_valid = 1'b0;
    tick();
    chk("stream_drained", {31'd0, out_valid}, 32'd0);

    // Backpressure into the skid entry
    in_valid = 1'b1; in_data = 32'hA; out_ready = 1'b1;
    tick();
    chk("bp_first", out_data, 32'hA);
    out_ready = 1'b0; in_data = 32'hB;
    tick();
    chk("bp_full_in_ready", {31'd0, in_ready}, 32'd0);
    chk("bp_skid_holds_b",  u_dut.u_skid.q, 32'hB);
    in_data = 32'hC;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("bp_hold_data",     out_data, 32'hA);
      chk("bp_hold_in_ready", {31'd0, in_ready},  32'd0);
      chk("bp_hold_valid",    {31'd0, out_valid}, 32'd1);
    end
    out_ready = 1'b1;
    tick();
    chk("bp_rel_b",        out_data, 32'hB);
    chk("bp_rel_in_ready", {31'd0, in_ready}, 32'd1);
    tick();
    chk("bp_rel_c", out_data, 32'hC);
    in_valid = 1'b0;
    tick();
    chk("bp_empty", {31'd0, out_valid}, 32'd0);
    chk("bp_sb_empty", sb_q.size(), 32'd0);

    // Flush while FULL, with handshakes offered in the flush cycle
    in_valid = 1'b1; in_data = 32'h11; out_ready = 1'b1;
    tick();
    out_ready = 1'b0; in_data = 32'h22;
    tick();
    chk("fl_pre_full", {31'd0, in_ready}, 32'd0);
    flush = 1'b1; out_ready = 1'b1; in_data = 32'h33;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    chk("fl_out_valid", {31'd0, out_valid}, 32'd0);
    chk("fl_out_data",  out_data, RV);
    chk("fl_in_ready",  {31'd0, in_ready}, 32'd1);
    chk("fl_skid_rv",   u_dut.u_skid.q, RV);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("fl_no_reappear", {31'd0, out_valid}, 32'd0);
    end

    // Reset while BUSY
    in_valid = 1'b1; in_data = 32'h44; out_ready = 1'b0;
    tick();
    chk("mr_busy", out_data, 32'h44);
    rst = 1'b0; in_data = 32'h55; out_ready = 1'b1;
    tick();
    rst = 1'b1; in_valid = 1'b0;
    chk("mr_out_valid", {31'd0, out_valid}, 32'd0);
    chk("mr_in_ready",  {31'd0, in_ready},  32'd1);
    chk("mr_out_data",  out_data, RV);
    tick();
    chk("mr_no_emit", {31'd0, out_valid}, 32'd0);

    // Idle hold in BUSY
    in_valid = 1'b1; in_data = 32'h66; out_ready = 1'b1;
    tick();
    in_valid = 1'b0; out_ready = 1'b0; in_data = 32'h99;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("idle_data",  out_data, 32'h66);
      chk("idle_valid", {31'd0, out_valid}, 32'd1);
    end
    out_ready = 1'b1;
    tick();
    chk("idle_drain", {31'd0, out_valid}, 32'd0);

`ifdef PIPE_REG_PERF_EN
    rst = 1'b0;
    tick();
    rst = 1'b1;
    chk("perf_rst0", stall_cnt, 32'd0);
    in_valid = 1'b1; in_data = 32'h77; out_ready = 1'b1;
    tick();
    in_valid = 1'b0; out_ready = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    chk("perf_stall5", stall_cnt, 32'd5);
    flush = 1'b1; out_ready = 1'b1;
    tick();
    flush = 1'b0;
    chk("perf_flush_keep", stall_cnt, 32'd5);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    chk("perf_rst_clear", stall_cnt, 32'd0);
`endif

    chk("sb_final_empty", sb_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
